// File: rtl/lfsr_engine.sv
// Parametrised Fibonacci/Galois LFSR with multi-shift advance, zero-state guard,
// advance counter and registered match pulse.
module lfsr_engine #(
    parameter int                 WIDTH     = 20,
    parameter logic [WIDTH-1:0]   FTAPS     = 20'h08881,
    parameter logic [WIDTH-1:0]   GTAPS     = 20'h81110,
    parameter int                 STEPS_MAX = 4,
    parameter int                 CNT_W     = 16,
    parameter int                 SEED_W    = 128,
    parameter int                 SN_W      = $clog2(STEPS_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEED_W-1:0] seed_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [SN_W-1:0]   steps_n_i,
    input  logic              mode_i,
    input  logic              match_en_i,
    input  logic [WIDTH-1:0]  match_val_i,
    output logic [WIDTH-1:0]  lfsr_o,
    output logic              match_o,
    output logic              lockup_o,
    output logic [CNT_W-1:0]  cnt_o
);

    logic [WIDTH-1:0] seed_low;
    logic             seed_zero;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] next_state;
    logic             shifted_zero;
    logic             advance;

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s,
                                                    input logic galois);
        if (galois)
            return (s >> 1) ^ (s[0] ? GTAPS : '0);
        else
            return {^(s & FTAPS), s[WIDTH-1:1]};
    endfunction

    assign seed_low  = seed_i[WIDTH-1:0];
    assign seed_zero = (seed_low == '0);
    assign advance   = step_i && (steps_n_i != '0);

    // The loop bound clamps the request at STEPS_MAX shifts.
    always_comb begin
        // NOTE: blocking assignments here chain each shift into the next within one evaluation.
        shifted = lfsr_o;
        for (int i = 0; i < STEPS_MAX; i++) begin
            if (SN_W'(i) < steps_n_i)
                shifted = shift_once(shifted, mode_i);
        end
        shifted_zero = (shifted == '0);
        next_state   = shifted_zero ? WIDTH'(1) : shifted;
    end

    always_ff @(posedge clk) begin
        if (rst || load_i) begin
            lfsr_o   <= seed_zero ? WIDTH'(1) : seed_low;
            lockup_o <= seed_zero;
            cnt_o    <= '0;
            match_o  <= 1'b0;
        end else if (advance) begin
            lfsr_o   <= next_state;
            if (shifted_zero)
                lockup_o <= 1'b1;
            cnt_o    <= cnt_o + CNT_W'(1);
            match_o  <= match_en_i && (next_state == match_val_i);
        end else begin
            match_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lfsr_engine.sv
// Bench for lfsr_engine: default 20-bit instance plus a small 8-bit instance for
// full-period and counter-wrap runs, both checked every cycle against a reference model.
module tb_lfsr_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance A: defaults
    logic          rst_a, load_a, step_a, mode_a, me_a;
    logic [127:0]  seed_a;
    logic [2:0]    sn_a;
    logic [19:0]   mv_a, lfsr_a;
    logic          match_a, lock_a;
    logic [15:0]   cnt_a;

    // Instance B: 8-bit, x^8+x^6+x^5+x^4+1 family
    logic          rst_b, load_b, step_b, mode_b, me_b;
    logic [15:0]   seed_b;
    logic [1:0]    sn_b;
    logic [7:0]    mv_b, lfsr_b;
    logic          match_b, lock_b;
    logic [3:0]    cnt_b;

    lfsr_engine dut_a (
        .clk(clk), .rst(rst_a), .seed_i(seed_a), .load_i(load_a), .step_i(step_a),
        .steps_n_i(sn_a), .mode_i(mode_a), .match_en_i(me_a), .match_val_i(mv_a),
        .lfsr_o(lfsr_a), .match_o(match_a), .lockup_o(lock_a), .cnt_o(cnt_a)
    );

    lfsr_engine #(
        .WIDTH(8), .FTAPS(8'h1D), .GTAPS(8'hB8), .STEPS_MAX(3), .CNT_W(4), .SEED_W(16)
    ) dut_b (
        .clk(clk), .rst(rst_b), .seed_i(seed_b), .load_i(load_b), .step_i(step_b),
        .steps_n_i(sn_b), .mode_i(mode_b), .match_en_i(me_b), .match_val_i(mv_b),
        .lfsr_o(lfsr_b), .match_o(match_b), .lockup_o(lock_b), .cnt_o(cnt_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_adv(input logic [63:0] s, input int k, input logic galois,
                                              input int w, input logic [63:0] ft,
                                              input logic [63:0] gt);
        for (int j = 0; j < k; j++) begin
            if (galois)
                s = (s >> 1) ^ (s[0] ? gt : 64'd0);
            else
                s = (s >> 1) | (64'($countones(s & ft) % 2) << (w - 1));
        end
        return s;
    endfunction

    task automatic model_edge(input int w, input int smax, input int cw,
                              input logic [63:0] ft, input logic [63:0] gt,
                              input logic r, input logic ld, input logic st, input int sn,
                              input logic md, input logic me, input logic [63:0] mv,
                              input logic [63:0] sd,
                              inout logic [63:0] s, inout logic [63:0] c,
                              inout logic m, inout logic lk);
        logic [63:0] wm;
        logic [63:0] cm;
        int k;
        wm = (64'd1 << w) - 64'd1;
        cm = (64'd1 << cw) - 64'd1;
        if (r || ld) begin
            s  = sd & wm;
            lk = (s == 64'd0);
            if (s == 64'd0) s = 64'd1;
            c  = 64'd0;
            m  = 1'b0;
        end else if (st && sn != 0) begin
            k = (sn < smax) ? sn : smax;
            s = model_adv(s, k, md, w, ft, gt) & wm;
            if (s == 64'd0) begin
                s  = 64'd1;
                lk = 1'b1;
            end
            c = (c + 64'd1) & cm;
            m = me && (s == (mv & wm));
        end else begin
            m = 1'b0;
        end
    endtask

    logic [63:0] ea_s, ea_c, eb_s, eb_c;
    logic        ea_m, ea_l, eb_m, eb_l;
    bit          va = 1'b0, vb = 1'b0;

    always @(posedge clk) begin
        model_edge(20, 4, 16, 64'h08881, 64'h81110, rst_a, load_a, step_a, int'(sn_a),
                   mode_a, me_a, 64'(mv_a), seed_a[63:0], ea_s, ea_c, ea_m, ea_l);
        model_edge(8, 3, 4, 64'h1D, 64'hB8, rst_b, load_b, step_b, int'(sn_b),
                   mode_b, me_b, 64'(mv_b), 64'(seed_b), eb_s, eb_c, eb_m, eb_l);
        if (rst_a) va = 1'b1;
        if (rst_b) vb = 1'b1;
    end

    // Cycle-by-cycle comparison, away from the active edge
    always @(negedge clk) begin
        if (va) begin
            check("a_lfsr",  64'(lfsr_a),  ea_s);
            check("a_cnt",   64'(cnt_a),   ea_c);
            check("a_match", 64'(match_a), 64'(ea_m));
            check("a_lock",  64'(lock_a),  64'(ea_l));
        end
        if (vb) begin
            check("b_lfsr",  64'(lfsr_b),  eb_s);
            check("b_cnt",   64'(cnt_b),   eb_c);
            check("b_match", 64'(match_b), 64'(eb_m));
            check("b_lock",  64'(lock_b),  64'(eb_l));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_a_seed(input logic [127:0] sd);
        load_a = 1'b1; step_a = 1'b0; seed_a = sd;
        tick();
        load_a = 1'b0;
    endtask

    task automatic run_period(input logic galois, input string tag);
        int first;
        int pulses;
        load_b = 1'b1; step_b = 1'b0; seed_b = 16'h0001; mode_b = galois;
        me_b = 1'b1; mv_b = 8'h00; sn_b = 2'd1;
        tick();
        load_b = 1'b0; step_b = 1'b1;
        first = 0; pulses = 0;
        for (int i = 1; i <= 300 && first == 0; i++) begin
            tick();
            if (match_b) pulses++;
            if (lfsr_b == 8'h01) first = i;
        end
        check({tag, "_period"}, 64'(first), 64'd255);
        check({tag, "_pulses"}, 64'(pulses), 64'd0);
        step_b = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; load_a = 1'b0; step_a = 1'b0; mode_a = 1'b0; me_a = 1'b0;
        seed_a = 128'h1; sn_a = 3'd1; mv_a = '0;
        rst_b = 1'b1; load_b = 1'b0; step_b = 1'b0; mode_b = 1'b0; me_b = 1'b0;
        seed_b = 16'h1; sn_b = 2'd1; mv_b = '0;
        tick();
        rst_a = 1'b0; rst_b = 1'b0;
        check("rst_lfsr",  64'(lfsr_a),  64'h00001);
        check("rst_cnt",   64'(cnt_a),   64'd0);
        check("rst_lock",  64'(lock_a),  64'd0);
        check("rst_match", 64'(match_a), 64'd0);

        // Fibonacci single shifts
        step_a = 1'b1; sn_a = 3'd1;
        tick(); check("fib_step1", 64'(lfsr_a), 64'h80000);
        tick(); check("fib_step2", 64'(lfsr_a), 64'h40000);
        check("fib_cnt2", 64'(cnt_a), 64'd2);

        // Multi-shift and clamp
        load_a_seed(128'h1);
        step_a = 1'b1; sn_a = 3'd2;
        tick(); check("multi2", 64'(lfsr_a), 64'h40000);
        check("multi2_cnt", 64'(cnt_a), 64'd1);
        load_a_seed(128'h1);
        step_a = 1'b1; sn_a = 3'd7;
        tick(); check("clamp7", 64'(lfsr_a), 64'h10000);

        // Galois
        load_a_seed(128'h1);
        mode_a = 1'b1; step_a = 1'b1; sn_a = 3'd1;
        tick(); check("gal_step1", 64'(lfsr_a), 64'h81110);

        // Zero seed, sticky lockup, non-zero reload
        mode_a = 1'b0;
        load_a_seed(128'h0);
        check("zero_lfsr", 64'(lfsr_a), 64'h1);
        check("zero_lock", 64'(lock_a), 64'd1);
        step_a = 1'b1;
        tick(); check("lock_sticky", 64'(lock_a), 64'd1);
        load_a_seed(128'h12345);
        check("reload_lock", 64'(lock_a), 64'd0);
        check("reload_lfsr", 64'(lfsr_a), 64'h12345);
        step_a = 1'b1;
        tick();
        load_a = 1'b1; seed_a = 128'h00ABC;
        tick(); load_a = 1'b0;
        check("ld_step_lfsr", 64'(lfsr_a), 64'h00ABC);
        check("ld_step_cnt",  64'(cnt_a),  64'd0);

        // Match pulse
        me_a = 1'b1; mv_a = 20'h40000;
        load_a_seed(128'h1);
        step_a = 1'b1;
        tick(); check("match_no1", 64'(match_a), 64'd0);
        tick(); check("match_hit", 64'(match_a), 64'd1);
        step_a = 1'b0;
        tick(); check("match_drop", 64'(match_a), 64'd0);
        me_a = 1'b0;
        load_a_seed(128'h1);
        step_a = 1'b1;
        tick(); tick(); check("match_dis", 64'(match_a), 64'd0);

        // Hold with steps_n=0
        sn_a = 3'd0;
        tick();
        check("hold_lfsr", 64'(lfsr_a), 64'h40000);
        check("hold_cnt",  64'(cnt_a),  64'd2);

        // rst beats a would-be matching advance
        me_a = 1'b1; mv_a = 20'h20000; sn_a = 3'd1; rst_a = 1'b1; seed_a = 128'h1;
        tick(); rst_a = 1'b0; step_a = 1'b0;
        check("rst_mid_lfsr",  64'(lfsr_a),  64'h1);
        check("rst_mid_cnt",   64'(cnt_a),   64'd0);
        check("rst_mid_match", 64'(match_a), 64'd0);

        // Small instance: full periods and counter wrap
        run_period(1'b1, "gal");
        run_period(1'b0, "fib");
        load_b = 1'b1; seed_b = 16'h0005;
        tick(); load_b = 1'b0; step_b = 1'b1; sn_b = 2'd1; me_b = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("cnt_15", 64'(cnt_b), 64'd15);
        tick(); check("cnt_wrap", 64'(cnt_b), 64'd0);

        // Randomised phase
        for (int n = 0; n < 3000; n++) begin
            int ka;
            int kb;
            rst_a  = ($urandom % 64) == 0;
            load_a = ($urandom % 16) == 0;
            step_a = ($urandom % 4) != 0;
            sn_a   = 3'($urandom % 8);
            mode_a = 1'($urandom % 2);
            me_a   = 1'($urandom % 2);
            seed_a = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom % 8 == 0) seed_a[19:0] = '0;
            ka = (int'(sn_a) < 4) ? int'(sn_a) : 4;
            if ($urandom % 3 == 0)
                mv_a = 20'(model_adv(ea_s, ka, mode_a, 20, 64'h08881, 64'h81110));
            else
                mv_a = 20'($urandom);

            rst_b  = ($urandom % 64) == 0;
            load_b = ($urandom % 16) == 0;
            step_b = ($urandom % 4) != 0;
            sn_b   = 2'($urandom % 4);
            mode_b = 1'($urandom % 2);
            me_b   = 1'($urandom % 2);
            seed_b = 16'($urandom);
            if ($urandom % 8 == 0) seed_b[7:0] = '0;
            kb = int'(sn_b);
            if ($urandom % 3 == 0)
                mv_b = 8'(model_adv(eb_s, kb, mode_b, 8, 64'h1D, 64'hB8));
            else
                mv_b = 8'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_engine.md
# lfsr_engine

Parametrised linear-feedback shift register engine that generalises the fixed 20-bit trigger LFSR. It provides configurable width and polynomial, Fibonacci or Galois mode, and multiple shifts per advance. It also guards against the all-zero lock-up state, counts advances, and flags a match against a programmable value. It sits behind trigger/sequence logic as a pseudo-random stream source seeded from the 128-bit data path.

## Interface
- WIDTH, 20: register width in bits, 2..64.
- FTAPS, 20'h08881: Fibonacci feedback mask; new MSB = XOR of state bits whose mask bit is 1 (x^20+x^13+x^9+x^5+1).
- GTAPS, 20'h81110: Galois toggle mask, XORed into the shifted state when the outgoing bit state[0] is 1.
- STEPS_MAX, 4: maximum shifts per advance, 1..8.
- CNT_W, 16: advance-counter width.
- SEED_W, 128: seed bus width, ≥ WIDTH.
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- seed_i  in  SEED_W  seed; low WIDTH bits are used.
- load_i  in  1  load seed on this edge.
- step_i  in  1  advance enable (trigger).
- steps_n_i  in  clog2(STEPS_MAX+1)  shifts per advance.
- mode_i  in  1  0 = Fibonacci, 1 = Galois.
- match_en_i  in  1  enable match detection.
- match_val_i  in  WIDTH  compare value.
- lfsr_o  out  WIDTH  current state, registered.
- match_o  out  1  single-cycle pulse, aligned with lfsr_o.
- lockup_o  out  1  sticky flag: a zero seed was substituted.
- cnt_o  out  CNT_W  advances since last reset/load.

## Operation
- Priority per edge: rst > load_i > step_i > hold.
- rst and load_i behave identically:
  - state <= seed_i[WIDTH-1:0], cnt_o <= 0, match_o <= 0.
  - If the seed low bits are all zero, state <= 1 and lockup_o <= 1; otherwise lockup_o <= 0.
- Fibonacci single shift: state <= {^(state & FTAPS), state[WIDTH-1:1]}.
- Galois single shift: state <= (state >> 1) ^ (state[0] ? GTAPS : 0).
- Advance on step_i=1 (no rst, no load):
  - The single shift is applied k times combinationally in one cycle, k = min(steps_n_i, STEPS_MAX).
  - steps_n_i=0 means hold: state and cnt_o are unchanged and match_o=0.
  - For k≥1, cnt_o increments by 1 per advance (not per shift) and wraps modulo 2^CNT_W with no flag.
- mode_i and steps_n_i are sampled on the advancing edge only; a change between steps takes effect on the next advance.
- Match: match_o <= match_en_i & advance(k≥1) & (next_state == match_val_i).
  - match_o never asserts on rst or load, or while holding.
- Non-zero-preserving: with a non-zero state, neither mode can reach zero for valid (primitive) masks. If the computed next state is nonetheless zero, state <= 1 and lockup_o <= 1.
- lockup_o clears only on rst or on a load of a non-zero seed.

## Timing
- Reset values:
  - lfsr_o = seed_i[WIDTH-1:0], or 1 if that is zero.
  - match_o = 0.
  - lockup_o = 1 only for a zero seed, else 0.
  - cnt_o = 0.
- Latency 1: inputs sampled at edge N are reflected on the outputs after edge N.
- match_o is high for exactly one cycle per qualifying advance; it is asserted back-to-back if consecutive advances match.
- load_i and step_i asserted on the same edge: the load wins and no shift is applied.
- rst asserted mid-stream: the next edge discards the pending advance.
- Fully synchronous; no combinational path from inputs to outputs.

## Test plan
- Fibonacci basics (defaults; rst with seed 0x00001, then step_i=1, steps_n=1):
  - After rst: lfsr_o=0x00001.
  - After step 1: lfsr_o=0x80000.
  - After step 2: lfsr_o=0x40000, cnt_o=2.
- Multi-step: from seed 0x00001, one advance with steps_n=2 -> lfsr_o=0x40000, cnt_o=1; steps_n=7 with STEPS_MAX=4 equals four shifts.
- Galois: mode_i=1, seed 0x00001, one step -> lfsr_o=0x81110.
  - Run 2^20-1 steps -> lfsr_o returns to 0x00001 with no zero state and no match pulses.
  - Repeat the full-period check in Fibonacci mode.
- Zero seed and priority:
  - load_i with seed 0 -> lfsr_o=0x00001, lockup_o=1.
  - Load seed 0x12345 -> lockup_o=0.
  - load_i and step_i on the same edge -> lfsr_o=seed and cnt_o=0.
- Match: match_en=1, match_val=0x40000, seed 1, two steps -> match_o high for exactly the cycle where lfsr_o=0x40000; with match_en=0 no pulse.
- Hold, wrap and reset:
  - With CNT_W=4, 16 advances -> cnt_o wraps to 0.
  - steps_n=0 with step_i=1 -> no change.
  - rst asserted alongside step_i -> seed reloaded, cnt_o=0, match_o=0.
